// File: rtl/adder_hf_1bit.sv
// adder_hf_1bit
//   Registered 1-bit half adder with one-cycle latency and three saturating
//   event counters (accepted pairs, pairs with sum=1, pairs with carry=1).
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset, released synchronously
//   in_valid   qualifies in1/in2 on a rising edge
//   in1, in2   addend bits
//   clr        synchronous clear of the event counters
//   out        registered sum bit of the last accepted pair
//   carry      registered carry bit of the last accepted pair
//   out_valid  one-cycle pulse following each accepted pair
//   op_cnt     accepted pairs, saturating at 2^CNT_W-1
//   sum_cnt    accepted pairs with sum=1, saturating
//   carry_cnt  accepted pairs with carry=1, saturating

module adder_hf_1bit_satcnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    // clr wins over a same-cycle increment: that pair is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end
endmodule

module adder_hf_1bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in1,
    input  logic             in2,
    input  logic             clr,
    output logic             out,
    output logic             carry,
    output logic             out_valid,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] sum_cnt,
    output logic [CNT_W-1:0] carry_cnt
);
    localparam int STAGES = 1;
    localparam int NCNT   = 3;

    typedef struct packed {
        logic sum;
        logic carry;
    } hf_res_t;

    hf_res_t              res_d, res_q;
    logic [STAGES:1]      vld_pipe;
    logic [NCNT-1:0]      inc;
    logic [NCNT-1:0][CNT_W-1:0] cnt;

    assign res_d.sum   = in1 ^ in2;
    assign res_d.carry = in1 & in2;

    // Increment strobes gated by in_valid so that anything on in1/in2 while
    // idle (including X) never reaches the counters.
    assign inc = {res_d.carry, res_d.sum, 1'b1} & {NCNT{in_valid}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            // Result registers hold across idle cycles.
            if (in_valid)
                res_q <= res_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCNT; g++) begin : g_cnt
            adder_hf_1bit_satcnt #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .inc   (inc[g]),
                .cnt   (cnt[g])
            );
        end
    endgenerate

    assign out       = res_q.sum;
    assign carry     = res_q.carry;
    assign out_valid = vld_pipe[STAGES];
    assign op_cnt    = cnt[0];
    assign sum_cnt   = cnt[1];
    assign carry_cnt = cnt[2];
endmodule

// File: tb/tb_adder_hf_1bit.sv
module tb_adder_hf_1bit;
    localparam int W  = 8;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in1 = 1'b0, in2 = 1'b0, clr = 1'b0;

    logic          out_b, carry_b, vld_b;
    logic [W-1:0]  op_b, sum_b, car_b;
    logic          out_s, carry_s, vld_s;
    logic [WS-1:0] op_s, sum_s, car_s;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // reference model state: what the registers should hold
    int m_out, m_carry, m_vld;
    int mb_op, mb_sum, mb_car;
    int ms_op, ms_sum, ms_car;

    always #5 clk = ~clk;

    adder_hf_1bit #(.CNT_W(W)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2), .clr(clr),
        .out(out_b), .carry(carry_b), .out_valid(vld_b),
        .op_cnt(op_b), .sum_cnt(sum_b), .carry_cnt(car_b)
    );

    adder_hf_1bit #(.CNT_W(WS)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2), .clr(clr),
        .out(out_s), .carry(carry_s), .out_valid(vld_s),
        .op_cnt(op_s), .sum_cnt(sum_s), .carry_cnt(car_s)
    );

    function automatic logic [3+3*W-1:0] act_b();
        return {out_b, carry_b, vld_b, op_b, sum_b, car_b};
    endfunction
    function automatic logic [3+3*W-1:0] exp_b();
        return {m_out[0], m_carry[0], m_vld[0], W'(mb_op), W'(mb_sum), W'(mb_car)};
    endfunction
    function automatic logic [3+3*WS-1:0] act_s();
        return {out_s, carry_s, vld_s, op_s, sum_s, car_s};
    endfunction
    function automatic logic [3+3*WS-1:0] exp_s();
        return {m_out[0], m_carry[0], m_vld[0], WS'(ms_op), WS'(ms_sum), WS'(ms_car)};
    endfunction

    function automatic int sat_add(int v, int inc, int maxv);
        return (v + inc > maxv) ? maxv : v + inc;
    endfunction

    task automatic model_reset();
        m_out = 0; m_carry = 0; m_vld = 0;
        mb_op = 0; mb_sum = 0; mb_car = 0;
        ms_op = 0; ms_sum = 0; ms_car = 0;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model,
    // and return 1 time unit after the edge.
    task automatic step(input logic v, input logic a, input logic b, input logic c);
        int total, s, k;
        in_valid = v; in1 = a; in2 = b; clr = c;
        @(posedge clk);
        if (rst_n) begin
            m_vld = v;
            if (v) begin
                total   = int'(a) + int'(b);
                m_out   = total % 2;
                m_carry = total / 2;
            end
            s = (v && (int'(a) + int'(b)) == 1) ? 1 : 0;
            k = (v && (int'(a) + int'(b)) == 2) ? 1 : 0;
            if (c) begin
                mb_op = 0; mb_sum = 0; mb_car = 0;
                ms_op = 0; ms_sum = 0; ms_car = 0;
            end else begin
                mb_op  = sat_add(mb_op,  int'(v), (1 << W) - 1);
                mb_sum = sat_add(mb_sum, s,       (1 << W) - 1);
                mb_car = sat_add(mb_car, k,       (1 << W) - 1);
                ms_op  = sat_add(ms_op,  int'(v), (1 << WS) - 1);
                ms_sum = sat_add(ms_sum, s,       (1 << WS) - 1);
                ms_car = sat_add(ms_car, k,       (1 << WS) - 1);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        chk_cnt++;
        if (act_b() !== exp_b()) $display("FAIL reset_state act=%h exp=%h", act_b(), exp_b());
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk_cnt++;
            if (act_b() !== '0) $display("FAIL idle_after_reset cyc=%0d act=%h exp=0", i, act_b());
            else pass_cnt++;
        end
    endtask

    task automatic test_pattern();
        logic [3:0] exp_o, exp_c;
        exp_o = 4'b0110;   // index = pair number 0..3
        exp_c = 4'b1000;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 10; r++) begin
            for (int p = 0; p < 4; p++) begin
                step(1'b1, p[1], p[0], 1'b0);
                chk_cnt++;
                if (out_b !== exp_o[p] || carry_b !== exp_c[p] || vld_b !== 1'b1)
                    $display("FAIL pattern r=%0d p=%0d out/carry/vld=%b%b%b exp=%b%b1",
                             r, p, out_b, carry_b, vld_b, exp_o[p], exp_c[p]);
                else pass_cnt++;
                chk_cnt++;
                if (act_b() !== exp_b()) $display("FAIL pattern_model act=%h exp=%h", act_b(), exp_b());
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (op_b !== 8'd40 || sum_b !== 8'd20 || car_b !== 8'd10)
            $display("FAIL pattern_counts op/sum/car=%0d/%0d/%0d exp=40/20/10", op_b, sum_b, car_b);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (out_b !== 1'b1 || carry_b !== 1'b0 || vld_b !== 1'b1 || op_b !== 8'd1)
            $display("FAIL hold_accept out/carry/vld/op=%b%b%b/%0d exp=101/1", out_b, carry_b, vld_b, op_b);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            chk_cnt++;
            if (out_b !== 1'b1 || carry_b !== 1'b0 || vld_b !== 1'b0 || op_b !== 8'd1)
                $display("FAIL hold_idle cyc=%0d out/carry/vld/op=%b%b%b/%0d exp=100/1",
                         i, out_b, carry_b, vld_b, op_b);
            else pass_cnt++;
        end
    endtask

    task automatic test_clr();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_cnt++;
        if (op_b === '0 || car_b === '0) $display("FAIL clr_precond op/car=%0d/%0d exp nonzero", op_b, car_b);
        else pass_cnt++;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_cnt++;
        if (op_b !== '0 || sum_b !== '0 || car_b !== '0 || carry_b !== 1'b1 || out_b !== 1'b0 || vld_b !== 1'b1)
            $display("FAIL clr_with_pair cnt=%0d/%0d/%0d out/carry/vld=%b%b%b exp=0/0/0 011",
                     op_b, sum_b, car_b, out_b, carry_b, vld_b);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            chk_cnt++;
            if (act_s() !== exp_s()) $display("FAIL sat_model cyc=%0d act=%h exp=%h", i, act_s(), exp_s());
            else pass_cnt++;
        end
        chk_cnt++;
        if (op_s !== 2'd3 || car_s !== 2'd3 || sum_s !== 2'd0)
            $display("FAIL sat_final op/sum/car=%0d/%0d/%0d exp=3/0/3", op_s, sum_s, car_s);
        else pass_cnt++;
    endtask

    task automatic test_xin();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'bx, 1'bx, 1'b0);
            chk_cnt++;
            if (act_b() !== exp_b()) $display("FAIL x_idle cyc=%0d act=%h exp=%h", i, act_b(), exp_b());
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 31) == 0));
            chk_cnt++;
            if (act_b() !== exp_b() || act_s() !== exp_s() || (out_b & carry_b) !== 1'b0)
                $display("FAIL random cyc=%0d act=%h/%h exp=%h/%h", i, act_b(), act_s(), exp_b(), exp_s());
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i[0], 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_cnt++;
        if (act_b() !== '0 || act_s() !== '0) $display("FAIL async_reset act=%h/%h exp=0", act_b(), act_s());
        else pass_cnt++;
        // pair presented while in reset must be discarded
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_cnt++;
        if (act_b() !== '0) $display("FAIL reset_discard act=%h exp=0", act_b());
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (act_b() !== exp_b() || op_b !== 8'd1 || out_b !== 1'b1)
            $display("FAIL first_after_reset act=%h exp=%h", act_b(), exp_b());
        else pass_cnt++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pattern();
        test_hold();
        test_clr();
        test_saturate();
        test_xin();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
